uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered 8N1 UART transmitter for the board top levels. It drives the on-board FTDI receive line (`uart_rxd_out`) from a small byte FIFO, which gives status and debug output the opposite direction to the Prop Plug receive path. It runs entirely in the `clock_160` domain and sits beside the p1v core. Arbitration of the shared FTDI line against pin 30 is done in the top level, not here.

## Interface

Parameters:
- `BAUD_DIV`, 1389: clock cycles per bit, 160 MHz / 115200 rounded. Legal range 2..65535.
- `FIFO_DEPTH`, 16: byte slots. Must be a power of two, 2..256.

Ports:
- `clock_160`, in, 1: system clock. All logic is rising-edge.
- `inp_resn`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: permits new frames to start.
- `wr_data`, in, 8: byte to enqueue.
- `wr_valid`, in, 1: write request.
- `wr_ready`, out, 1: FIFO not full. Combinational from `count`.
- `tx`, out, 1: serial output, idle high. Registered.
- `busy`, out, 1: a frame is in progress. Registered.
- `count`, out, $clog2(FIFO_DEPTH)+1: bytes held in the FIFO. Excludes the byte in the shifter.

## Operation

- **Reset.** While `inp_resn` is low: `tx`=1, `busy`=0, `count`=0, `wr_ready`=1, FIFO pointers 0, state IDLE. Reset asserted mid-frame truncates the frame immediately. No stop bit is emitted and queued data is discarded.
- **Write.** A byte is accepted on an edge where `wr_valid & wr_ready`. When `count==FIFO_DEPTH`, `wr_valid` is ignored: no overwrite, no error flag.
- **FIFO.** Circular buffer with wrap-around pointers.
  - Pop and push on the same edge leave `count` unchanged.
  - When full, a pop does not make `wr_ready` high in the same cycle. Ready rises on the cycle after the pop.
- **State machine.** States are IDLE, START, DATA, STOP.
  - IDLE -> START when `enable & count!=0`. The byte is popped into the shifter, the bit counter is cleared and `busy` is set.
  - START: `tx`=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: `tx`=shifter[0], LSB first, each bit held BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles. Then:
    - if `enable & count!=0`, go straight to START with the next byte. There is no idle gap between frames.
    - otherwise go to IDLE and clear `busy`.
- **Enable.** Sampled only in IDLE and at the end of STOP. Deasserting `enable` mid-frame does not abort the frame. Writes continue to be accepted while `enable` is low.
- **Baud counter.** Width is $clog2(BAUD_DIV). It reloads at every bit boundary and never free-runs in IDLE, so the first start bit is exactly BAUD_DIV cycles long.

## Timing

- **Latency.** Byte written at edge N into an empty FIFO, with IDLE and `enable`=1: pop at edge N+1, and `tx` falls after edge N+2. `busy` rises after N+1.
- **Frame length.** Exactly 10·BAUD_DIV cycles from the falling start edge to the end of the stop bit. Back-to-back frames have a period of exactly 10·BAUD_DIV.
- **Throughput.** One byte per 10·BAUD_DIV cycles. The FIFO absorbs bursts of up to FIFO_DEPTH bytes, plus one byte in the shifter.
- **Output glitches.** `tx` and `busy` are flop outputs. `wr_ready` may change only after a clock edge or a reset assertion.

## Test plan

- **Reset values.** Hold `inp_resn`=0 with random inputs: `tx`=1, `busy`=0, `count`=0, `wr_ready`=1.
- **Single byte, BAUD_DIV=4.** Write 0xA5 -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). First low comes 2 edges after the write. `busy` clears after the stop bit.
- **Fill and overflow, DEPTH=4, `enable`=0.** Write 0x01..0x06 -> `count`=4, `wr_ready`=0, and 0x05/0x06 are dropped. Raise `enable` -> 0x01..0x04 are sent back-to-back with no idle cycles, and `count` ends at 0.
- **Simultaneous push/pop.** With `count`=2, write on the edge the STOP->START pop occurs -> `count` stays 2, and bytes go out in write order.
- **Enable drop mid-frame.** Deassert `enable` during DATA bit 3 with 2 bytes queued -> the current frame completes, then IDLE with `tx`=1 and `count`=2.
- **Reset mid-frame.** Pulse `inp_resn` low in DATA -> `tx`=1 asynchronously and `count`=0. After release with no writes, `tx` stays high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed shifter

// Circular byte buffer with power-of-two depth; pointers wrap naturally.
module uart_tx_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resn,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Ready is derived from the registered count only, so a pop while full
  // lets ready rise on the following cycle, never within the same one.
  assign ready    = (count != FULL);
  assign push_ok  = push & ready;
  assign pop_ok   = pop & (count != '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Top level: FIFO plus a four-state frame generator driving the serial line.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 1389,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock_160,
  input  logic                          inp_resn,
  input  logic                          enable,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shifter;
  logic [7:0]    fifo_data;
  logic          bit_done;
  logic          pop;

  // The baud counter counts down; zero marks the last cycle of the current bit.
  assign bit_done = (baud_cnt == '0);

  // A new frame is launched from IDLE or at the very end of a stop bit, so
  // back-to-back frames have no idle gap and enable is only sampled there.
  assign pop = enable & (count != '0) &
               ((state == IDLE) | ((state == STOP) & bit_done));

  uart_tx_fifo_buf #(
    .DEPTH     (FIFO_DEPTH)
  ) u_buf (
    .clk       (clock_160),
    .resn      (inp_resn),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (count),
    .ready     (wr_ready)
  );

  // Frame state machine; tx is registered from the current state so each
  // level appears one cycle after the state is entered and lasts BAUD_DIV cycles.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shifter  <= fifo_data;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_LAST;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          tx <= 1'b0;
          if (bit_done) begin
            baud_cnt <= BAUD_LAST;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        DATA: begin
          tx <= shifter[0];
          if (bit_done) begin
            baud_cnt <= BAUD_LAST;
            shifter  <= {1'b0, shifter[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            if (pop) begin
              shifter  <= fifo_data;
              bit_cnt  <= '0;
              baud_cnt <= BAUD_LAST;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
      endcase
    end
  end

endmodule
